// File: rtl/alu_mon_pkg.sv
// alu_mon_pkg: shared types for alu_result_monitor; ALU_MON_TIMESTAMP_EN adds sample_idx to log records.
package alu_mon_pkg;
  typedef struct packed {
    logic [3:0] result;
    logic       carry;
    logic       zero;
    logic       overflow;
  } alu_vec_t;
  typedef enum logic {ARMED, ALARM} mon_state_e;
  typedef struct packed {
    alu_vec_t a;
    alu_vec_t b;
  } alu_pair_t;
  localparam int PAIR_W = $bits(alu_pair_t);
`ifdef ALU_MON_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  function automatic int log_w(input int cnt_w);
    return TS_EN ? cnt_w + PAIR_W : PAIR_W;
  endfunction
endpackage

// File: rtl/alu_mon_fifo.sv
// alu_mon_fifo: synchronous first-word-fall-through FIFO; head holds the last popped word when empty.
module alu_mon_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] last_q;
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;
  always_comb begin
    empty = wr_ptr == rd_ptr;
    full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    do_pop = pop & ~empty & ~flush;
    do_push = push & (~full | do_pop) & ~flush;
    pop_data = empty ? last_q : mem[rd_ptr[AW-1:0]];
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_q <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
        last_q <= mem[rd_ptr[AW-1:0]];
      end
    end
endmodule

// File: rtl/alu_result_monitor.sv
// alu_result_monitor: compares reference/suspect ALU WB outputs, counts samples/mismatches, logs mismatches.
// Define ALU_MON_TIMESTAMP_EN to prefix each log record with its sample index.
module alu_result_monitor
  import alu_mon_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16,
  parameter int ALARM_THRESH = 1,
  localparam int LOG_W = log_w(CNT_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             wb_valid,
  input  logic [3:0]       result_a,
  input  logic [3:0]       result_b,
  input  logic             carry_a,
  input  logic             zero_a,
  input  logic             overflow_a,
  input  logic             carry_b,
  input  logic             zero_b,
  input  logic             overflow_b,
  input  logic             log_rd,
  output logic [LOG_W-1:0] log_data,
  output logic             log_empty,
  output logic             log_full,
  output logic             log_dropped,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             alarm
);
  alu_vec_t         vec_a, vec_b, s1_a, s1_b;
  logic             s1_valid, s1_mis, push;
  logic [CNT_W-1:0] sample_nxt, mismatch_nxt;
  logic [LOG_W-1:0] rec;
  mon_state_e       state, state_nxt;
  always_comb begin
    vec_a = {result_a, carry_a, zero_a, overflow_a};
    vec_b = {result_b, carry_b, zero_b, overflow_b};
    push = s1_valid & s1_mis;
    sample_nxt = (s1_valid && sample_cnt != '1) ? sample_cnt + CNT_W'(1) : sample_cnt;
    mismatch_nxt = (push && mismatch_cnt != '1) ? mismatch_cnt + CNT_W'(1) : mismatch_cnt;
    state_nxt = (state == ARMED && mismatch_nxt >= CNT_W'(ALARM_THRESH)) ? ALARM : state;
    alarm = state == ALARM;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mis <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      sample_cnt <= '0;
      mismatch_cnt <= '0;
      log_dropped <= 1'b0;
      state <= ARMED;
    end else if (clear) begin
      s1_valid <= 1'b0;
      sample_cnt <= '0;
      mismatch_cnt <= '0;
      log_dropped <= 1'b0;
      state <= ARMED;
    end else begin
      s1_valid <= wb_valid;
      if (wb_valid) begin
        s1_a <= vec_a;
        s1_b <= vec_b;
        s1_mis <= vec_a !== vec_b;
      end
      sample_cnt <= sample_nxt;
      mismatch_cnt <= mismatch_nxt;
      state <= state_nxt;
      if (push && log_full && !log_rd) log_dropped <= 1'b1;
    end
`ifdef ALU_MON_TIMESTAMP_EN
  logic [CNT_W-1:0] s1_idx;
  // index includes the sample still in stage 2 so back-to-back samples get distinct indices
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s1_idx <= '0;
    else if (wb_valid && !clear) s1_idx <= sample_nxt;
  always_comb rec = {s1_idx, s1_a, s1_b};
`else
  always_comb rec = {s1_a, s1_b};
`endif
  alu_mon_fifo #(.DEPTH(DEPTH), .W(LOG_W)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .flush(clear),
    .push(push),
    .push_data(rec),
    .pop(log_rd),
    .pop_data(log_data),
    .full(log_full),
    .empty(log_empty)
  );
endmodule

// File: tb/tb_alu_result_monitor.sv
// tb_alu_result_monitor: table-driven single-sample vectors plus directed multi-cycle sequences.
module tb_alu_result_monitor;
  import alu_mon_pkg::*;
  localparam int LW = log_w(16);
  localparam int LW4 = log_w(4);
  typedef struct {
    logic [3:0] ra;
    logic [2:0] fa;
    logic [3:0] rb;
    logic [2:0] fb;
    logic       mis;
  } vec_t;
  logic clk = 0, rst_n = 0, clear = 0, wb_valid = 0, log_rd = 0;
  logic [3:0] result_a = 0, result_b = 0;
  logic carry_a = 0, zero_a = 0, overflow_a = 0, carry_b = 0, zero_b = 0, overflow_b = 0;
  logic [LW-1:0] log_data;
  logic log_empty, log_full, log_dropped, alarm;
  logic [15:0] sample_cnt, mismatch_cnt;
  logic [LW4-1:0] s_log_data;
  logic s_empty, s_full, s_dropped, s_alarm;
  logic [3:0] s_sample_cnt, s_mismatch_cnt;
  int total = 0, bad = 0;
  vec_t tbl [7];
  always #5 clk = ~clk;
  alu_result_monitor dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .wb_valid(wb_valid),
    .result_a(result_a), .result_b(result_b),
    .carry_a(carry_a), .zero_a(zero_a), .overflow_a(overflow_a),
    .carry_b(carry_b), .zero_b(zero_b), .overflow_b(overflow_b),
    .log_rd(log_rd), .log_data(log_data), .log_empty(log_empty), .log_full(log_full),
    .log_dropped(log_dropped), .sample_cnt(sample_cnt), .mismatch_cnt(mismatch_cnt), .alarm(alarm)
  );
  alu_result_monitor #(.CNT_W(4)) sat (
    .clk(clk), .rst_n(rst_n), .clear(clear), .wb_valid(wb_valid),
    .result_a(result_a), .result_b(result_b),
    .carry_a(carry_a), .zero_a(zero_a), .overflow_a(overflow_a),
    .carry_b(carry_b), .zero_b(zero_b), .overflow_b(overflow_b),
    .log_rd(log_rd), .log_data(s_log_data), .log_empty(s_empty), .log_full(s_full),
    .log_dropped(s_dropped), .sample_cnt(s_sample_cnt), .mismatch_cnt(s_mismatch_cnt), .alarm(s_alarm)
  );
  function automatic logic [LW-1:0] rec(input int idx, input logic [6:0] a, input logic [6:0] b);
`ifdef ALU_MON_TIMESTAMP_EN
    return {16'(idx), a, b};
`else
    return {a, b};
`endif
  endfunction
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic v, input logic [3:0] ra, input logic [2:0] fa,
                     input logic [3:0] rb, input logic [2:0] fb);
    wb_valid = v;
    result_a = ra;
    {carry_a, zero_a, overflow_a} = fa;
    result_b = rb;
    {carry_b, zero_b, overflow_b} = fb;
  endtask
  task automatic do_clear();
    put(0, 0, 0, 0, 0);
    clear = 1;
    step();
    clear = 0;
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_scnt"}, 64'(sample_cnt), 0);
    chk({tag, "_mcnt"}, 64'(mismatch_cnt), 0);
    chk({tag, "_empty"}, 64'(log_empty), 1);
    chk({tag, "_full"}, 64'(log_full), 0);
    chk({tag, "_drop"}, 64'(log_dropped), 0);
    chk({tag, "_data"}, 64'(log_data), 0);
    chk({tag, "_alarm"}, 64'(alarm), 0);
    chk({tag, "_sat_scnt"}, 64'(s_sample_cnt), 0);
  endtask
  initial begin
    tbl[0] = '{4'd8, 3'b000, 4'd8, 3'b000, 1'b0};
    tbl[1] = '{4'd8, 3'b000, 4'd9, 3'b000, 1'b1};
    tbl[2] = '{4'd5, 3'b100, 4'd5, 3'b000, 1'b1};
    tbl[3] = '{4'd0, 3'b010, 4'd0, 3'b010, 1'b0};
    tbl[4] = '{4'd0, 3'b010, 4'd0, 3'b000, 1'b1};
    tbl[5] = '{4'd7, 3'b001, 4'd7, 3'b000, 1'b1};
    tbl[6] = '{4'd15, 3'b111, 4'd15, 3'b111, 1'b0};
    #1;
    chk_reset_vals("reset");
    #12 rst_n = 1;
    step();
    // 100 matching samples (3+5=8 on both sides)
    for (int i = 0; i < 10; i++) begin put(1, 8, 0, 8, 0); step(); end
    put(0, 0, 0, 0, 0);
    step();
    chk("m10_scnt", 64'(sample_cnt), 10);
    chk("m10_sat_scnt", 64'(s_sample_cnt), 10);
    for (int i = 0; i < 90; i++) begin put(1, 8, 0, 8, 0); step(); end
    put(0, 0, 0, 0, 0);
    step();
    chk("m100_scnt", 64'(sample_cnt), 100);
    chk("m100_mcnt", 64'(mismatch_cnt), 0);
    chk("m100_empty", 64'(log_empty), 1);
    chk("m100_alarm", 64'(alarm), 0);
    chk("sat_scnt", 64'(s_sample_cnt), 15);
    // single mismatch as sample 7, back-to-back with 7 matches
    do_clear();
    for (int i = 0; i < 7; i++) begin put(1, 8, 0, 8, 0); step(); end
    put(1, 8, 0, 9, 0);
    step();
    put(0, 0, 0, 0, 0);
    chk("s7_lat_mcnt", 64'(mismatch_cnt), 0);
    chk("s7_lat_alarm", 64'(alarm), 0);
    chk("s7_lat_empty", 64'(log_empty), 1);
    step();
    chk("s7_mcnt", 64'(mismatch_cnt), 1);
    chk("s7_scnt", 64'(sample_cnt), 8);
    chk("s7_alarm", 64'(alarm), 1);
    chk("s7_data", 64'(log_data), 64'(rec(7, 7'h40, 7'h48)));
    log_rd = 1;
    step();
    log_rd = 0;
    chk("s7_pop_empty", 64'(log_empty), 1);
    chk("s7_pop_hold", 64'(log_data), 64'(rec(7, 7'h40, 7'h48)));
    step();
    chk("s7_alarm_held", 64'(alarm), 1);
    // table of single-sample vectors
    for (int i = 0; i < 7; i++) begin
      do_clear();
      put(1, tbl[i].ra, tbl[i].fa, tbl[i].rb, tbl[i].fb);
      step();
      put(0, 0, 0, 0, 0);
      step();
      chk($sformatf("tbl%0d_scnt", i), 64'(sample_cnt), 1);
      chk($sformatf("tbl%0d_mcnt", i), 64'(mismatch_cnt), 64'(tbl[i].mis));
      chk($sformatf("tbl%0d_alarm", i), 64'(alarm), 64'(tbl[i].mis));
      chk($sformatf("tbl%0d_empty", i), 64'(log_empty), 64'(!tbl[i].mis));
      if (tbl[i].mis)
        chk($sformatf("tbl%0d_data", i), 64'(log_data), 64'(rec(0, {tbl[i].ra, tbl[i].fa}, {tbl[i].rb, tbl[i].fb})));
    end
    // 10 mismatches into depth-8 log, no reads
    do_clear();
    for (int i = 0; i < 10; i++) begin put(1, 4'(i), 0, 4'(15 - i), 0); step(); end
    put(0, 0, 0, 0, 0);
    step();
    chk("ovf_full", 64'(log_full), 1);
    chk("ovf_drop", 64'(log_dropped), 1);
    chk("ovf_mcnt", 64'(mismatch_cnt), 10);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("ovf_rec%0d", k), 64'(log_data), 64'(rec(k, {4'(k), 3'b0}, {4'(15 - k), 3'b0})));
      log_rd = 1;
      step();
      log_rd = 0;
    end
    chk("ovf_empty", 64'(log_empty), 1);
    log_rd = 1;
    step();
    log_rd = 0;
    chk("ovf_rd_empty_hold", 64'(log_data), 64'(rec(7, {4'd7, 3'b0}, {4'd8, 3'b0})));
    chk("ovf_drop_sticky", 64'(log_dropped), 1);
    // full log with simultaneous pop and push
    do_clear();
    for (int i = 0; i < 8; i++) begin put(1, 4'(i), 0, 4'(15 - i), 0); step(); end
    put(0, 0, 0, 0, 0);
    step();
    chk("fp_full", 64'(log_full), 1);
    put(1, 4'd8, 0, 4'd7, 0);
    step();
    put(0, 0, 0, 0, 0);
    log_rd = 1;
    step();
    log_rd = 0;
    chk("fp_full_after", 64'(log_full), 1);
    chk("fp_drop", 64'(log_dropped), 0);
    chk("fp_mcnt", 64'(mismatch_cnt), 9);
    for (int k = 1; k < 9; k++) begin
      chk($sformatf("fp_rec%0d", k), 64'(log_data), 64'(rec(k, {4'(k), 3'b0}, {4'(15 - k), 3'b0})));
      log_rd = 1;
      step();
      log_rd = 0;
    end
    chk("fp_empty", 64'(log_empty), 1);
    // clear coinciding with a mismatching sample, with state pending
    put(1, 4'd1, 0, 4'd2, 0);
    step();
    put(1, 4'd3, 0, 4'd4, 0);
    clear = 1;
    step();
    clear = 0;
    put(0, 0, 0, 0, 0);
    step();
    chk_reset_vals("clr");
    // async reset mid-stream
    for (int i = 0; i < 5; i++) begin put(1, 4'd2, 0, 4'd3, 0); step(); end
    chk("pre_rst_mcnt", 64'(mismatch_cnt), 4);
    #2 rst_n = 0;
    #1;
    chk_reset_vals("arst");
    put(0, 0, 0, 0, 0);
    #1 rst_n = 1;
    step();
    step();
    chk("arst_inflight_scnt", 64'(sample_cnt), 0);
    chk("arst_inflight_empty", 64'(log_empty), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
